// File: rtl/imem_load_pkg.sv
// Shared definitions for the instruction-memory load controller:
// chip mode encodings, frame sizing helper and controller FSM states.
package imem_load_pkg;

    localparam logic [1:0] MODE_DEBUG = 2'd0;
    localparam logic [1:0] MODE_LOAD  = 2'd1;
    localparam logic [1:0] MODE_RUN   = 2'd2;

    // Payload bytes needed to carry address + data, MSB first.
    function automatic int frame_bytes(input int aw, input int dw, input int bw);
        return (aw + dw + bw - 1) / bw;
    endfunction

    localparam int FRAME_BYTES_DEFAULT = frame_bytes(10, 40, 8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        WRITE   = 2'd3
    } state_e;

endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for the synchronised imem_clock level; one-cycle
// stroke when the level goes from low to high.
module strobe_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_i,
    output logic stroke_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= strobe_i;
        end
    end

    assign stroke_o = strobe_i & ~prev_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: assembles byte strokes from port A into
// address/data/checksum frames and writes validated words into the core imem.
module imem_load_ctrl
    import imem_load_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter int         DATA_W    = 40,
    parameter int         BYTE_W    = 8,
    parameter logic [1:0] LOAD_MODE = MODE_LOAD,
    parameter int         TIMEOUT   = 1024
) (
    input  logic              clk_int,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              strobe_in,
    output logic [ADDR_W-1:0] imem_write_adr,
    output logic [DATA_W-1:0] imem_in,
    output logic              imem_write,
    output logic              core_hold,
    output logic              busy,
    output logic [ADDR_W-1:0] word_count,
    output logic              err_cksum,
    output logic              err_timeout
);

    localparam int NB    = frame_bytes(ADDR_W, DATA_W, BYTE_W);
    localparam int PL_W  = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(NB + 2);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CKSUM_IDX = CNT_W'(NB);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [PL_W-1:0]   payload_q, payload_d;
    logic [BYTE_W-1:0] cksum_q, cksum_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic              err_ck_q, err_ck_d;
    logic              err_to_q, err_to_d;

    logic load_en;
    logic stroke;
    logic cksum_ok;

    strobe_edge_det u_edge (
        .clk_i   (clk_int),
        .rst_i   (reset),
        .strobe_i(strobe_in),
        .stroke_o(stroke)
    );

    assign load_en  = (mode == LOAD_MODE);
    // Running XOR covers payload and checksum byte, so a good frame folds to zero.
    assign cksum_ok = (cksum_q == '0);

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && !load_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (load_en) state_d = COLLECT;
                COLLECT: if (stroke && byte_cnt_q == CKSUM_IDX) state_d = CHECK;
                CHECK:   state_d = cksum_ok ? WRITE : COLLECT;
                WRITE:   state_d = COLLECT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_write = (state_q == WRITE) && load_en;
        core_hold  = load_en;
        busy       = (byte_cnt_q != '0);
    end

    always_comb begin
        payload_d  = payload_q;
        cksum_d    = cksum_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        adr_d      = adr_q;
        data_d     = data_q;
        wcnt_d     = wcnt_q;
        err_ck_d   = err_ck_q;
        err_to_d   = err_to_q;
        if (state_q != IDLE && !load_en) begin
            byte_cnt_d = '0;
            cksum_d    = '0;
            tmo_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_en) begin
                        wcnt_d     = '0;
                        err_ck_d   = 1'b0;
                        err_to_d   = 1'b0;
                        byte_cnt_d = '0;
                        cksum_d    = '0;
                        tmo_d      = '0;
                    end
                end
                COLLECT: begin
                    if (stroke) begin
                        // The checksum byte only feeds the XOR; leading pad bits fall off the top.
                        if (byte_cnt_q != CKSUM_IDX) begin
                            payload_d = {payload_q[PL_W-BYTE_W-1:0], byte_in};
                        end
                        cksum_d    = cksum_q ^ byte_in;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        tmo_d      = '0;
                    end else if (byte_cnt_q != '0) begin
                        if (tmo_q == TMO_LAST) begin
                            err_to_d   = 1'b1;
                            byte_cnt_d = '0;
                            cksum_d    = '0;
                            tmo_d      = '0;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (cksum_ok) begin
                        adr_d  = payload_q[DATA_W +: ADDR_W];
                        data_d = payload_q[DATA_W-1:0];
                    end else begin
                        err_ck_d   = 1'b1;
                        byte_cnt_d = '0;
                        cksum_d    = '0;
                    end
                end
                WRITE: begin
                    wcnt_d     = wcnt_q + ADDR_W'(1);
                    byte_cnt_d = '0;
                    cksum_d    = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_int or posedge reset) begin
        if (reset) begin
            payload_q  <= '0;
            cksum_q    <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            adr_q      <= '0;
            data_q     <= '0;
            wcnt_q     <= '0;
            err_ck_q   <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            payload_q  <= payload_d;
            cksum_q    <= cksum_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            adr_q      <= adr_d;
            data_q     <= data_d;
            wcnt_q     <= wcnt_d;
            err_ck_q   <= err_ck_d;
            err_to_q   <= err_to_d;
        end
    end

    assign imem_write_adr = adr_q;
    assign imem_in        = data_q;
    assign word_count     = wcnt_q;
    assign err_cksum      = err_ck_q;
    assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: frames are built from address/data
// values, expected writes are queued at stimulus time and checked by a monitor.
module tb_imem_load_ctrl;
    import imem_load_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 40;
    localparam int BYTE_W = 8;
    localparam int TMO    = 16;

    logic              clk_int = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        mode = 2'd0;
    logic [BYTE_W-1:0] byte_in = '0;
    logic              strobe_in = 1'b0;
    logic [ADDR_W-1:0] imem_write_adr;
    logic [DATA_W-1:0] imem_in;
    logic              imem_write;
    logic              core_hold;
    logic              busy;
    logic [ADDR_W-1:0] word_count;
    logic              err_cksum;
    logic              err_timeout;

    imem_load_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BYTE_W   (BYTE_W),
        .LOAD_MODE(MODE_LOAD),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_int       (clk_int),
        .reset         (reset),
        .mode          (mode),
        .byte_in       (byte_in),
        .strobe_in     (strobe_in),
        .imem_write_adr(imem_write_adr),
        .imem_in       (imem_in),
        .imem_write    (imem_write),
        .core_hold     (core_hold),
        .busy          (busy),
        .word_count    (word_count),
        .err_cksum     (err_cksum),
        .err_timeout   (err_timeout)
    );

    always #5 clk_int = ~clk_int;

    typedef struct {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
        int                cyc;
        logic [ADDR_W-1:0] wc;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    int                writes_seen = 0;
    int                writes_before;
    logic [ADDR_W-1:0] exp_wc = '0;

    always @(posedge clk_int) cyc <= cyc + 1;

    always @(posedge clk_int) begin
        if (cyc > 90000) begin
            $display("FAIL watchdog: got cycle %0d required < 90000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // Monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk_int) begin
        if (!reset && imem_write) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got adr=%h data=%h required no write",
                         imem_write_adr, imem_in);
            end else begin
                mon_e = exp_q.pop_front();
                if (imem_write_adr !== mon_e.adr || imem_in !== mon_e.data ||
                    cyc != mon_e.cyc || word_count !== mon_e.wc) begin
                    errors++;
                    $display("FAIL write: got adr=%h data=%h cyc=%0d wc=%0d required adr=%h data=%h cyc=%0d wc=%0d",
                             imem_write_adr, imem_in, cyc, word_count,
                             mon_e.adr, mon_e.data, mon_e.cyc, mon_e.wc);
                end else begin
                    $display("write adr=%h data=%h wc=%0d", imem_write_adr, imem_in, word_count);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_int);
        #1;
    endtask

    // One stroke: strobe high for one cycle then low for gap+1 cycles.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit push,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        @(posedge clk_int);
        #1;
        byte_in   = b;
        strobe_in = 1'b1;
        if (push) begin
            e.adr  = a;
            e.data = d;
            e.cyc  = cyc + 2;
            e.wc   = exp_wc;
            exp_q.push_back(e);
            exp_wc = exp_wc + 1'b1;
        end
        @(posedge clk_int);
        #1;
        strobe_in = 1'b0;
        repeat (gap) @(posedge clk_int);
    endtask

    // Frame = 6 pad bits, address, data (MSB first) then XOR checksum.
    // A nonzero bad_x corrupts the checksum so no write is expected.
    task automatic send_frame(input logic [5:0] pad, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [7:0] bad_x);
        logic [55:0] p;
        logic [7:0]  cks;
        p   = {pad, a, d};
        cks = '0;
        for (int i = 0; i < 7; i++) begin
            cks ^= p[55-8*i -: 8];
            send_byte(p[55-8*i -: 8], $urandom_range(1, 2), 1'b0, a, d);
        end
        send_byte(cks ^ bad_x, $urandom_range(1, 2), (bad_x == 8'h00), a, d);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), 1, 1'b0, '0, '0);
    endtask

    task automatic send_random_good();
        send_frame(6'($urandom), ADDR_W'($urandom), {8'($urandom), 32'($urandom)}, 8'h00);
    endtask

    initial begin
        #3;
        check("reset_outputs",
              {imem_write, imem_write_adr, imem_in, core_hold, busy, word_count, err_cksum, err_timeout},
              '0);
        @(negedge clk_int);
        reset = 1'b0;
        mode  = MODE_LOAD;
        wait_cyc(2);
        check("core_hold_load", core_hold, 1'b1);
        check("idle_busy", busy, 1'b0);

        // Directed good frame 00 05 12 34 56 78 9A / 97
        send_frame(6'h00, 10'h005, 40'h123456789A, 8'h00);
        wait_cyc(3);
        check("good_wc", word_count, exp_wc);
        check("good_errs", {err_cksum, err_timeout}, 2'b00);

        // Same payload with checksum 96, then the correct frame
        send_frame(6'h00, 10'h005, 40'h123456789A, 8'h01);
        wait_cyc(3);
        check("bad_err_cksum", err_cksum, 1'b1);
        check("bad_wc", word_count, exp_wc);
        check("bad_busy", busy, 1'b0);
        send_frame(6'h00, 10'h005, 40'h123456789A, 8'h00);
        wait_cyc(3);
        check("recover_wc", word_count, exp_wc);
        check("recover_err_sticky", err_cksum, 1'b1);

        // Inter-byte timeout
        send_partial(3);
        check("partial_busy", busy, 1'b1);
        check("partial_no_timeout", err_timeout, 1'b0);
        wait_cyc(TMO + 4);
        check("timeout_flag", err_timeout, 1'b1);
        check("timeout_busy", busy, 1'b0);
        send_random_good();
        wait_cyc(3);
        check("after_timeout_wc", word_count, exp_wc);

        // Mode exit mid-frame keeps status, re-entry clears it
        send_partial(5);
        mode = MODE_RUN;
        wait_cyc(2);
        check("exit_core_hold", core_hold, 1'b0);
        check("exit_busy", busy, 1'b0);
        check("exit_wc_kept", word_count, exp_wc);
        check("exit_flags_kept", {err_cksum, err_timeout}, 2'b11);
        mode = MODE_LOAD;
        exp_wc = '0;
        wait_cyc(2);
        check("reenter_status", {word_count, err_cksum, err_timeout}, '0);

        // Eighth stroke coincides with mode exit: no write
        send_partial(7);
        @(posedge clk_int);
        #1;
        byte_in   = 8'h3C;
        strobe_in = 1'b1;
        mode      = MODE_RUN;
        wait_cyc(1);
        strobe_in = 1'b0;
        wait_cyc(4);
        check("exit_race_busy", busy, 1'b0);
        check("exit_race_wc", word_count, exp_wc);
        mode = MODE_LOAD;
        exp_wc = '0;
        wait_cyc(2);

        // 1025 back-to-back frames wrap word_count
        writes_before = writes_seen;
        for (int f = 0; f < 1025; f++) send_random_good();
        wait_cyc(3);
        check("wrap_wc", word_count, exp_wc);
        check("wrap_writes", 64'(writes_seen - writes_before), 64'd1025);

        // Async reset mid-collect, then strobe held high across release
        send_partial(3);
        @(negedge clk_int);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {imem_write, imem_write_adr, imem_in, busy, word_count, err_cksum, err_timeout},
              '0);
        strobe_in = 1'b1;
        byte_in   = 8'hA5;
        exp_q.delete();
        exp_wc = '0;
        @(negedge clk_int);
        reset = 1'b0;
        wait_cyc(5);
        check("held_strobe_ignored", busy, 1'b0);
        strobe_in = 1'b0;
        wait_cyc(1);
        send_random_good();
        wait_cyc(3);
        check("post_reset_wc", word_count, exp_wc);

        wait_cyc(4);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
